// File: rtl/store_unit_pkg.sv
// Shared constants and types for the store unit: st_sel encodings, FIFO depth, lane masks
// and the buffered entry layout.
package store_unit_pkg;

    typedef enum logic [1:0] {
        SelB   = 2'b00,
        SelH   = 2'b01,
        SelW   = 2'b10,
        SelIll = 2'b11
    } st_sel_e;

    localparam int unsigned FifoDepth = 2;
    localparam logic [1:0]  CountFull = 2'(FifoDepth);

    localparam logic [3:0] MaskB = 4'b0001;
    localparam logic [3:0] MaskH = 4'b0011;
    localparam logic [3:0] MaskW = 4'b1111;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  mask;
    } st_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational lane alignment and byte-enable generation for SB/SH/SW, plus misalignment
// detection. Only the low two address bits matter here.
module store_align
    import store_unit_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    input  logic [1:0]  sel,
    output logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        mask       = 4'b0000;
        misaligned = 1'b0;
        unique case (st_sel_e'(sel))
            SelB: begin
                wdata = {4{data[7:0]}};
                mask  = MaskB << offset;
            end
            SelH: begin
                wdata      = {2{data[15:0]}};
                mask       = MaskH << offset;
                misaligned = offset[0];
            end
            SelW: begin
                mask       = MaskW;
                misaligned = |offset;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: aligns stores, buffers them in a 2-entry FIFO and drains them to DMem/IO.
// Define STORE_FWD_EN to build store-to-load forwarding; otherwise ld_* outputs are tied to 0.
module store_unit
    import store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_sel,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_we,
    output logic        misalign,
    output logic        buf_empty,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_fwd_data,
    output logic [3:0]  ld_fwd_mask
);

    st_entry_t   buf_q [FifoDepth];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        rst_q;
    logic        misalign_q;

    logic [31:0] al_data;
    logic [3:0]  al_mask;
    logic        al_bad;
    logic        accept, enq, deq;
    st_entry_t   head, new_entry;

    store_align u_align (
        .offset     (st_addr[1:0]),
        .data       (st_data),
        .sel        (st_sel),
        .wdata      (al_data),
        .mask       (al_mask),
        .misaligned (al_bad)
    );

    // rst_q keeps st_ready low through reset and releases it one cycle after deassertion.
    assign st_ready  = !rst_q && (count_q != CountFull);
    assign accept    = st_valid && st_ready;
    assign enq       = accept && !al_bad;
    assign buf_empty = (count_q == 2'd0);
    assign misalign  = misalign_q;

    assign head      = buf_q[rd_ptr_q];
    assign mem_valid = (count_q != 2'd0) && !rst;
    assign mem_addr  = {head.waddr, 2'b00};
    assign mem_din   = head.data;
    assign mem_we    = mem_valid ? head.mask : 4'b0000;
    assign deq       = mem_valid && mem_ready;

    assign new_entry = '{waddr: st_addr[31:2], data: al_data, mask: al_mask};

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rst_q      <= 1'b1;
            misalign_q <= 1'b0;
        end else begin
            rst_q      <= 1'b0;
            count_q    <= count_d;
            misalign_q <= accept && al_bad;
            if (enq) begin
                buf_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

`ifdef STORE_FWD_EN
    st_entry_t newest, oldest;
    logic      hit_new, hit_old;
    logic      unused_ld;

    // The newest entry sits just behind the write pointer; the older one (if any) at it.
    assign newest    = buf_q[~wr_ptr_q];
    assign oldest    = buf_q[wr_ptr_q];
    assign hit_new   = (count_q != 2'd0) && (newest.waddr == ld_addr[31:2]);
    assign hit_old   = (count_q == CountFull) && (oldest.waddr == ld_addr[31:2]);
    assign unused_ld = ^ld_addr[1:0];

    always_comb begin
        ld_hit      = 1'b0;
        ld_fwd_data = 32'h0;
        ld_fwd_mask = 4'b0000;
        if (hit_new) begin
            ld_hit      = 1'b1;
            ld_fwd_data = newest.data;
            ld_fwd_mask = newest.mask;
        end else if (hit_old) begin
            ld_hit      = 1'b1;
            ld_fwd_data = oldest.data;
            ld_fwd_mask = oldest.mask;
        end
    end
`else
    logic unused_ld;

    assign unused_ld   = ^ld_addr;
    assign ld_hit      = 1'b0;
    assign ld_fwd_data = 32'h0;
    assign ld_fwd_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: a queue-based model of the store buffer is checked every
// cycle by a negedge monitor, driven by directed scenarios followed by random traffic.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic [1:0]  st_sel = 2'b00;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic        misalign;
    logic        buf_empty;
    logic [31:0] ld_addr = 32'h0;
    logic        ld_hit;
    logic [31:0] ld_fwd_data;
    logic [3:0]  ld_fwd_mask;

    store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_sel      (st_sel),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .misalign    (misalign),
        .buf_empty   (buf_empty),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_fwd_data (ld_fwd_data),
        .ld_fwd_mask (ld_fwd_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    ent_t pend[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   writes_seen = 0;
    bit   m_rst = 1'b1;
    bit   m_mis = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one store request, from the width/offset rules.
    function automatic void model_store(input logic [1:0] sel, input logic [31:0] a,
                                        input logic [31:0] d, output bit bad, output ent_t e);
        int unsigned off;
        off    = a % 4;
        e.addr = a - off;
        e.data = d;
        e.mask = 4'b0000;
        bad    = 1'b0;
        case (sel)
            2'd0: begin
                e.data = (d & 32'hFF) * 32'h01010101;
                e.mask = 4'(1 << off);
            end
            2'd1: begin
                e.data = (d & 32'hFFFF) * 32'h00010001;
                e.mask = 4'(3 << off);
                bad    = (off % 2) != 0;
            end
            2'd2: begin
                e.mask = 4'hF;
                bad    = off != 0;
            end
            default: bad = 1'b1;
        endcase
    endfunction

    bit          exp_ready, exp_mv, exp_hit, bad, acc;
    logic [31:0] exp_fd;
    logic [3:0]  exp_fm;
    ent_t        e;

    always @(negedge clk) begin
        exp_ready = !m_rst && (pend.size() != 2);
        exp_mv    = !rst && (pend.size() != 0);
        check("st_ready", 32'(st_ready), 32'(exp_ready));
        check("buf_empty", 32'(buf_empty), 32'(pend.size() == 0));
        check("misalign", 32'(misalign), 32'(m_mis));
        check("mem_valid", 32'(mem_valid), 32'(exp_mv));
        if (exp_mv) begin
            check("mem_addr", mem_addr, pend[0].addr);
            check("mem_din", mem_din, pend[0].data);
            check("mem_we", 32'(mem_we), 32'(pend[0].mask));
        end else begin
            check("mem_we_idle", 32'(mem_we), 32'h0);
        end

        exp_hit = 1'b0;
        exp_fd  = 32'h0;
        exp_fm  = 4'h0;
`ifdef STORE_FWD_EN
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (!exp_hit && pend[i].addr == {ld_addr[31:2], 2'b00}) begin
                exp_hit = 1'b1;
                exp_fd  = pend[i].data;
                exp_fm  = pend[i].mask;
            end
        end
`endif
        check("ld_hit", 32'(ld_hit), 32'(exp_hit));
        check("ld_fwd_data", ld_fwd_data, exp_fd);
        check("ld_fwd_mask", 32'(ld_fwd_mask), 32'(exp_fm));

        // Advance the model across the coming rising edge (inputs are stable until then).
        if (rst) begin
            pend.delete();
            m_rst = 1'b1;
            m_mis = 1'b0;
        end else begin
            acc   = st_valid && exp_ready;
            m_mis = 1'b0;
            if (exp_mv && mem_ready) begin
                void'(pend.pop_front());
                writes_seen++;
            end
            if (acc) begin
                model_store(st_sel, st_addr, st_data, bad, e);
                if (bad) m_mis = 1'b1;
                else     pend.push_back(e);
            end
            m_rst = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_sel   = sel;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        #1 check("ready_after_reset", 32'(st_ready), 32'h1);

        // SB to the top byte lane.
        req(2'd0, 32'h0000_1003, 32'h0000_00AB);
        #1;
        check("sb_mem_valid", 32'(mem_valid), 32'h1);
        check("sb_mem_addr", mem_addr, 32'h0000_1000);
        check("sb_mem_we", 32'(mem_we), 32'h8);
        check("sb_lane3", 32'(mem_din[31:24]), 32'hAB);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;

        // Misaligned SH: handshake completes, nothing queued, one-cycle misalign pulse.
        req(2'd1, 32'h0000_2001, 32'h0000_BEEF);
        #1;
        check("sh_mis_pulse", 32'(misalign), 32'h1);
        check("sh_mis_no_write", 32'(mem_valid), 32'h0);
        check("sh_mis_empty", 32'(buf_empty), 32'h1);
        step();
        check("sh_mis_drop", 32'(misalign), 32'h0);

        // Three back-to-back SW against a stalled memory.
        st_valid = 1'b1;
        st_sel   = 2'd2;
        st_addr  = 32'h0000_4000; st_data = 32'hA0A0_A0A0; step();
        st_addr  = 32'h0000_4004; st_data = 32'hB1B1_B1B1; step();
        #1 check("full_not_ready", 32'(st_ready), 32'h0);
        st_addr  = 32'h0000_4008; st_data = 32'hC2C2_C2C2; step();
        st_valid  = 1'b0;
        mem_ready = 1'b1;
        step();
        #1 check("drain_order", mem_addr, 32'h0000_4004);
        step();
        #1;
        check("drain_empty", 32'(buf_empty), 32'h1);
        check("drain_ready", 32'(st_ready), 32'h1);
        mem_ready = 1'b0;

        // Simultaneous enqueue and dequeue with one entry pending.
        req(2'd2, 32'h0000_5000, 32'h1234_5678);
        st_valid  = 1'b1;
        st_addr   = 32'h0000_5004;
        st_data   = 32'h9ABC_DEF0;
        mem_ready = 1'b1;
        step();
        st_valid  = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("swap_addr", mem_addr, 32'h0000_5004);
        check("swap_data", mem_din, 32'h9ABC_DEF0);
        check("swap_one_left", 32'(st_ready && !buf_empty), 32'h1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;

        // Forwarding: newest matching entry wins.
        ld_addr = 32'h0000_3000;
        req(2'd2, 32'h0000_3000, 32'h1111_1111);
        req(2'd0, 32'h0000_3000, 32'h0000_0022);
        #1;
`ifdef STORE_FWD_EN
        check("fwd_hit", 32'(ld_hit), 32'h1);
        check("fwd_mask", 32'(ld_fwd_mask), 32'h1);
        check("fwd_lane0", 32'(ld_fwd_data[7:0]), 32'h22);
`else
        check("fwd_off_hit", 32'(ld_hit), 32'h0);
`endif

        // Reset with two entries pending and memory ready: nothing may be written.
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1 check("rst_no_write", 32'(mem_valid), 32'h0);
        step();
        rst = 1'b0;
        #1 check("rst_empty", 32'(buf_empty), 32'h1);
        step();
        #1 check("rst_ready", 32'(st_ready), 32'h1);
        mem_ready = 1'b0;

        // Random traffic around a few shared words so forwarding and stalls interact.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom % 100) == 0;
            st_valid  = ($urandom % 10) < 6;
            st_sel    = 2'($urandom % 4);
            st_addr   = 32'h100 + 4 * ($urandom % 4) + ($urandom % 4);
            if (($urandom % 4) == 0) st_addr[31:12] = 20'($urandom);
            st_data   = $urandom;
            mem_ready = ($urandom % 2) == 1;
            ld_addr   = 32'h100 + 4 * ($urandom % 4) + ($urandom % 4);
            step();
        end

        rst       = 1'b0;
        st_valid  = 1'b0;
        mem_ready = 1'b1;
        repeat (4) step();
        #1 check("final_empty", 32'(buf_empty), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port st_valid, input, 1: store request offered by Execute.
REQ-004 SHALL have port st_ready, output, 1: unit accepts a request this cycle.
REQ-005 SHALL have port st_addr, input, 32: store byte address from the ALU.
REQ-006 SHALL have port st_data, input, 32: unaligned rs2 value.
REQ-007 SHALL have port st_sel, input, 2: store width; 00=SB, 01=SH, 10=SW, 11=illegal.
REQ-008 SHALL have port mem_valid, output, 1: write presented to DMem/IO.
REQ-009 SHALL have port mem_ready, input, 1: memory consumes the write this cycle.
REQ-010 SHALL have port mem_addr, output, 32: word-aligned address {addr[31:2],2'b00}.
REQ-011 SHALL have port mem_din, output, 32: lane-aligned write data.
REQ-012 SHALL have port mem_we, output, 4: byte write enables, one bit per byte lane.
REQ-013 SHALL have port misalign, output, 1: one-cycle pulse for a rejected request.
REQ-014 SHALL have port buf_empty, output, 1: no pending stores (fence/drain).
REQ-015 SHALL have port ld_addr, input, 32: address of the load in Memory_Access.
REQ-016 SHALL have port ld_hit, output, 1: load address matches a pending store.
REQ-017 SHALL have port ld_fwd_data, output, 32: forwarded store data.
REQ-018 SHALL have port ld_fwd_mask, output, 4: valid byte lanes of ld_fwd_data.

Function
REQ-019 SHALL buffer stores in a 2-entry FIFO of {word addr, data, mask}, with 1-bit wrapping pointers and a 0..2 count.
REQ-020 SHALL accept a request when st_valid && st_ready; st_ready = (count != 2), derived from registered state only (no bypass when full, even if mem_ready=1).
REQ-021 SHALL align SB as data[7:0] replicated to all lanes with mask 4'b0001<<addr[1:0]; SH as data[15:0] in both halves with mask 4'b0011<<addr[1:0]; SW as data with mask 4'b1111.
REQ-022 SHALL treat SH with addr[0]=1, SW with addr[1:0]!=0, and st_sel=11 as misaligned: the handshake completes but nothing is enqueued, and misalign is high the following cycle only.
REQ-023 SHALL present the head entry on mem_* beginning the cycle after acceptance (1-cycle latency from empty).
REQ-024 SHALL hold mem_valid, mem_addr, mem_din and mem_we stable while mem_valid && !mem_ready; the head is dequeued on mem_valid && mem_ready.
REQ-025 SHALL drive mem_we=0 whenever mem_valid=0.
REQ-026 SHALL, on a simultaneous enqueue and dequeue with count=1, leave count at 1 and present the new entry the next cycle.
REQ-027 SHALL set buf_empty = (count == 0).
REQ-028 SHALL compute the forwarding outputs combinationally: ld_hit is set when ld_addr[31:2] equals any valid entry's address; on multiple hits the newest entry supplies ld_fwd_data and ld_fwd_mask.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear count and pointers, discard pending stores without issuing them, and drive mem_valid=0, mem_we=0, misalign=0, buf_empty=1, st_ready=0.
REQ-030 SHALL raise st_ready on the first cycle after rst deasserts; reset asserted mid-handshake drops that write.

Configuration
REQ-031 SHALL, with STORE_FWD_EN defined, implement REQ-028; without it, ld_hit, ld_fwd_data and ld_fwd_mask are tied to 0 and no comparators are built.

Structure
REQ-032 SHALL place the st_sel encodings (SB/SH/SW), FIFO depth 2 and mask constants in the shared core constants package.
REQ-033 SHALL implement alignment and mask generation (REQ-021/022) in one combinational sub-module, store_align.

Verification
REQ-034 SHALL cover: SB addr=0x1003, data=0x000000AB -> next cycle mem_addr=0x1000, mem_we=4'b1000, mem_din[31:24]=0xAB.
REQ-035 SHALL cover: SH addr=0x2001 -> no mem_valid, misalign high exactly one cycle, buf_empty stays 1.
REQ-036 SHALL cover: three back-to-back SW with mem_ready=0 -> third sees st_ready=0; mem_ready=1 drains both in order and st_ready returns.
REQ-037 SHALL cover: count=1 with simultaneous accept and mem_ready=1 -> count remains 1 and the new entry is presented next.
REQ-038 SHALL cover, with STORE_FWD_EN: SW 0x11111111 then SB 0x22 to the same word at addr[1:0]=0 pending, ld_addr same word -> ld_hit=1, ld_fwd_mask=4'b0001, lane0=0x22; without the macro, ld_hit=0.
REQ-039 SHALL cover: rst pulsed with 2 entries pending -> no write issued, buf_empty=1, st_ready=1 on the next cycle.
